// File: rtl/idct_pp_sched_pkg.sv
// Shared types and defaults for the IDCT ping/pong reorder-buffer scheduler.
package idct_pp_sched_pkg;

    localparam int W_PTS_DEF  = 12;
    localparam int W_FCNT_DEF = 16;

    // Per-buffer occupancy state; encoding is visible on the buf_state port.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_FILL  = 2'b01,
        BUF_FULL  = 2'b10,
        BUF_DRAIN = 2'b11
    } buf_state_e;

    // A buffer can take upstream beats while it is empty or part-way through a frame.
    function automatic logic can_accept(buf_state_e s);
        return (s == BUF_EMPTY) || (s == BUF_FILL);
    endfunction

endpackage

// File: rtl/idct_pp_sched_if.sv
// Upstream beat handshake from the scaling stage into the scheduler.
interface idct_pp_sched_if;

    logic up_valid;
    logic up_sop;
    logic up_eop;
    logic up_ready;

    modport master (output up_valid, output up_sop, output up_eop, input up_ready);
    modport slave  (input up_valid, input up_sop, input up_eop, output up_ready);

endinterface

// File: rtl/idct_pp_buf_fsm.sv
// Occupancy state machine for one reorder buffer (EMPTY -> FILL -> FULL -> DRAIN).
module idct_pp_buf_fsm
    import idct_pp_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       fill_start,
    input  logic       fill_done,
    input  logic       drain_go,
    input  logic       drain_done,
    output buf_state_e state
);

    buf_state_e state_q;
    buf_state_e state_d;

    // Next-state: a single-beat frame may start and finish in the same cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        case (state_q)
            BUF_EMPTY: begin
                if (fill_done)       state_d = BUF_FULL;
                else if (fill_start) state_d = BUF_FILL;
            end
            BUF_FILL: begin
                if (fill_done) state_d = BUF_FULL;
            end
            BUF_FULL: begin
                if (drain_go) state_d = BUF_DRAIN;
            end
            BUF_DRAIN: begin
                if (drain_done) state_d = BUF_EMPTY;
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values.
        if (rst) state_q <= BUF_EMPTY;
        else     state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/idct_pp_sched.sv
// Ping/pong reorder-buffer scheduler: steers frames into a free buffer, drains
// them to the output in frame order and flags malformed frames.
module idct_pp_sched
    import idct_pp_sched_pkg::*;
#(
    parameter int W_PTS  = W_PTS_DEF,
    parameter int W_FCNT = W_FCNT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_PTS-1:0]  cfg_fftpts,
    idct_pp_sched_if.slave    up,
    output logic              wr_sel,
    output logic [1:0]        wr_en,
    input  logic [1:0]        buf_valid,
    input  logic [1:0]        buf_eop,
    input  logic              dn_ready,
    output logic [1:0]        buf_rd_ready,
    output logic              rd_sel,
    output logic [3:0]        buf_state,
    output logic              err_sop,
    output logic              err_len,
    output logic [W_FCNT-1:0] frames_done
);

    buf_state_e st [2];

    logic [1:0] fill_start;
    logic [1:0] fill_done;
    logic [1:0] drain_go;
    logic [1:0] drain_done;

    logic              wr_sel_q,  wr_sel_d;
    logic              rd_sel_q,  rd_sel_d;
    logic [W_PTS-1:0]  n_q,       n_d;
    logic [W_PTS-1:0]  cnt_q,     cnt_d;
    logic [W_FCNT-1:0] frames_q,  frames_d;
    logic              err_sop_q, err_sop_d;
    logic              err_len_q, err_len_d;
    logic              rdy_en_q,  rdy_en_d;

    logic             acc;
    logic             legal;
    logic [W_PTS-1:0] beat_cnt;
    logic             rd_ok;
    buf_state_e       cur_st;
    buf_state_e       rd_st;

    for (genvar g = 0; g < 2; g++) begin : g_buf
        idct_pp_buf_fsm u_fsm (
            .clk        (clk),
            .rst        (rst),
            .fill_start (fill_start[g]),
            .fill_done  (fill_done[g]),
            .drain_go   (drain_go[g]),
            .drain_done (drain_done[g]),
            .state      (st[g])
        );
    end

    assign cur_st      = st[wr_sel_q];
    assign rd_st       = st[rd_sel_q];
    // Ready is held low through reset and the first edge after release.
    assign up.up_ready = rdy_en_q & can_accept(cur_st);
    assign acc         = up.up_valid & up.up_ready;

    // Write side: classify the accepted beat, track frame length, close frames.
    always_comb begin
        n_d        = n_q;
        cnt_d      = cnt_q;
        wr_sel_d   = wr_sel_q;
        err_sop_d  = 1'b0;
        err_len_d  = 1'b0;
        legal      = 1'b0;
        beat_cnt   = '0;
        fill_start = 2'b00;
        fill_done  = 2'b00;
        if (acc) begin
            if (up.up_sop) begin
                // A sop inside an open frame restarts it in the same buffer.
                err_sop_d = (cur_st == BUF_FILL);
                if (cfg_fftpts == '0) begin
                    err_len_d = 1'b1;
                end else begin
                    legal                = 1'b1;
                    n_d                  = cfg_fftpts;
                    beat_cnt             = W_PTS'(1);
                    fill_start[wr_sel_q] = 1'b1;
                end
            end else if (cur_st == BUF_EMPTY) begin
                err_sop_d = 1'b1;
            end else begin
                legal    = 1'b1;
                beat_cnt = cnt_q + W_PTS'(1);
            end
            if (legal) begin
                cnt_d = beat_cnt;
                // Frame closes on eop or when the length is reached without one.
                if (up.up_eop || (beat_cnt == n_d)) begin
                    fill_done[wr_sel_q] = 1'b1;
                    wr_sel_d            = ~wr_sel_q;
                    err_len_d           = (beat_cnt != n_d) || !up.up_eop;
                end
            end
        end
    end

    // Read side: only the buffer at rd_sel may drain, which keeps frame order.
    always_comb begin
        rd_sel_d     = rd_sel_q;
        frames_d     = frames_q;
        drain_go     = 2'b00;
        drain_done   = 2'b00;
        buf_rd_ready = 2'b00;
        rd_ok        = dn_ready && (rd_st == BUF_DRAIN);
        drain_go[rd_sel_q]     = (rd_st == BUF_FULL);
        buf_rd_ready[rd_sel_q] = rd_ok;
        if (rd_ok && buf_valid[rd_sel_q] && buf_eop[rd_sel_q]) begin
            drain_done[rd_sel_q] = 1'b1;
            rd_sel_d             = ~rd_sel_q;
            frames_d             = frames_q + W_FCNT'(1);
        end
    end

    assign rdy_en_d = 1'b1;

    // Scheduler registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            n_q       <= '0;
            cnt_q     <= '0;
            frames_q  <= '0;
            err_sop_q <= 1'b0;
            err_len_q <= 1'b0;
            rdy_en_q  <= 1'b0;
        end else begin
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            frames_q  <= frames_d;
            err_sop_q <= err_sop_d;
            err_len_q <= err_len_d;
            rdy_en_q  <= rdy_en_d;
        end
    end

    assign wr_sel      = wr_sel_q;
    assign rd_sel      = rd_sel_q;
    assign wr_en       = legal ? (wr_sel_q ? 2'b10 : 2'b01) : 2'b00;
    assign buf_state   = {st[1], st[0]};
    assign err_sop     = err_sop_q;
    assign err_len     = err_len_q;
    assign frames_done = frames_q;

endmodule
